fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the program-counter register: drives its enable, branch/jump selects and targets,
//  fetches each instruction over a req/ack instruction-memory port and presents it to decode through a
//  one-entry valid/ready output slot. Sits between PC register, instruction memory and decode/execute.
//  Owns redirects: wrong-path fetches are squashed; jump has priority over branch.
// PARAMETERS
//  PC_INC   1   sequential PC increment (word-addressed 16-bit memory)
//  TIMEOUT  15  ack wait limit in cycles, used only when FETCH_TIMEOUT_EN defined (range 1..255)
// PORTS
//  clock        in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  start        in   1   leave IDLE and begin fetching from pc_cur
//  halt         in   1   stop fetching after outstanding access completes
//  pc_cur       in   16  current PC from the PC register
//  pc_en        out  1   PC register load enable (one-cycle pulses)
//  pc_seq       out  16  sequential next PC = pc_cur + PC_INC, mod 2^16
//  pc_branch    out  1   PC branch select
//  pc_jump      out  1   PC jump select (overrides branch)
//  br_target    out  16  latched branch target
//  jmp_target   out  16  latched jump target
//  br_taken     in   1   execute: branch taken this cycle; br_addr valid
//  br_addr      in   16  branch target
//  jmp_taken    in   1   execute: jump this cycle; jmp_addr valid
//  jmp_addr     in   16  jump target
//  imem_req     out  1   memory request; held with imem_addr stable until imem_ack
//  imem_addr    out  16  fetch address (= pc_cur while imem_req)
//  imem_ack     in   1   memory response; imem_rdata valid same cycle
//  imem_rdata   in   16  instruction word
//  instr        out  16  fetched instruction
//  instr_pc     out  16  address of instr
//  instr_valid  out  1   output slot full
//  instr_ready  in   1   decode consumes slot when instr_valid & instr_ready
//  busy         out  1   state != IDLE
//  fetch_err    out  1   sticky timeout flag (FETCH_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except pc_seq (combinational, = pc_cur + PC_INC); redirect pending cleared.
//  States: IDLE, FETCH, WAIT, ERR (ERR only with macro).
//  IDLE: imem_req=0. start & ~halt -> FETCH. start & halt -> stay IDLE (halt wins).
//  FETCH: issue when slot free (~instr_valid or consumed this cycle): imem_req=1, addr=pc_cur -> WAIT.
//    Slot full and not consumed: remain FETCH, imem_req=0.
//  WAIT: imem_req held until imem_ack. On ack with no redirect: instr<=rdata, instr_pc<=pc_cur,
//    instr_valid<=1 next cycle; pc_en=1 with branch/jump=0 in ack cycle. Zero-wait memory gives one
//    instruction per 2 cycles (FETCH, WAIT).
//  Redirect (br_taken|jmp_taken) in IDLE/FETCH with no access outstanding: pc_en=1 same cycle,
//    pc_jump=jmp_taken, pc_branch=br_taken&~jmp_taken, targets passed through; slot flushed (instr_valid<=0).
//  Redirect during WAIT: target latched as pending; outstanding ack completes, data discarded
//    (instr_valid not set), pc_en pulses with pending select in the ack cycle. Redirect in ack cycle itself
//    is treated as pending-at-ack (same result). Later redirect overwrites earlier pending one.
//  Flush beats consume: redirect with instr_valid&instr_ready still drops the slot (counts as consumed).
//  halt: FETCH -> IDLE immediately; WAIT -> IDLE after ack (instruction delivered normally). Slot contents
//    retained across halt.
//  pc_en never asserted twice in one access; never asserted in IDLE except for redirects.
//  Reset mid-access: asynchronous return to IDLE, imem_req drops immediately; late ack ignored in IDLE.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: 8-bit wait counter cleared on entering WAIT; reaching TIMEOUT cycles without
//    ack -> ERR: imem_req=0, fetch_err=1 sticky, pc_en=0; leaves only via reset. Counter wraps never (saturates).
//  Undefined: no counter, WAIT waits indefinitely, ERR unreachable, fetch_err tied 0.
// TESTING
//  1 reset, pc_cur=0x0000, start, ack 1 cycle after req -> imem_addr 0x0000, instr_valid next cycle,
//    pc_en one pulse with selects 0, pc_seq=0x0001.
//  2 pc_cur=0xFFFF sequential ack -> pc_seq=0x0000 (wrap), instr_pc=0xFFFF.
//  3 jmp_taken addr 0x0200 and br_taken addr 0x0100 same cycle during WAIT -> ack data dropped,
//    pc_en with pc_jump=1, pc_branch=0, jmp_target=0x0200; next imem_addr follows pc_cur=0x0200.
//  4 instr_ready=0 for 5 cycles with slot full -> imem_req stays 0, instr stable; ready=1 -> new req same cycle.
//  5 halt asserted in WAIT, ack 3 cycles later -> instruction delivered, state IDLE, busy=0, no further req.
//  6 FETCH_TIMEOUT_EN, TIMEOUT=15, ack withheld -> fetch_err=1 after 15 WAIT cycles, imem_req=0; reset clears.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer that fetches over a req/ack instruction port into a one-entry decode slot.
// Optional FETCH_TIMEOUT_EN adds an ack-wait timeout with a sticky fetch_err and a parking ERR state.
module fetch_ctrl #(
    parameter logic [15:0] PC_INC  = 16'd1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt,
    input  logic [15:0] pc_cur,
    output logic        pc_en,
    output logic [15:0] pc_seq,
    output logic        pc_branch,
    output logic        pc_jump,
    output logic [15:0] br_target,
    output logic [15:0] jmp_target,
    input  logic        br_taken,
    input  logic [15:0] br_addr,
    input  logic        jmp_taken,
    input  logic [15:0] jmp_addr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        fetch_err
);

    // state | meaning
    // IDLE  | not fetching; only redirects reach the PC register
    // FETCH | issue a request at pc_cur once the output slot is free
    // WAIT  | request outstanding, held until imem_ack
    // ERR   | ack timed out; parked until reset (FETCH_TIMEOUT_EN only)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [15:0] addr_q, br_q, jmp_q;
    logic        pend_valid, pend_jmp, halt_pend;
    logic        active, redir, slot_free, issue, deliver, flush;

    assign active    = (state != ERR);
    assign redir     = (br_taken | jmp_taken) & active;
    assign slot_free = ~instr_valid | instr_ready;
    assign busy      = (state != IDLE);
    assign pc_seq    = pc_cur + PC_INC;
    assign flush     = redir;
    assign deliver   = (state == WAIT) & imem_ack & ~redir & ~pend_valid;

    // A redirect arriving this cycle is passed straight through; otherwise show the latched target.
    assign br_target  = (br_taken  && active) ? br_addr  : br_q;
    assign jmp_target = (jmp_taken && active) ? jmp_addr : jmp_q;
    assign imem_addr  = imem_req ? ((state == WAIT) ? addr_q : pc_cur) : 16'h0000;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       wait_tc;

    assign wait_tc   = (wait_cnt == 8'(TIMEOUT - 1));
    assign fetch_err = (state == ERR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'h00;
        end else if (issue) begin
            wait_cnt <= 8'h00;
        end else if (state == WAIT && !imem_ack && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_en     = 1'b0;
        pc_branch = 1'b0;
        pc_jump   = 1'b0;
        imem_req  = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (redir) begin
                    pc_en     = 1'b1;
                    pc_jump   = jmp_taken;
                    pc_branch = br_taken & ~jmp_taken;
                end
                if (start && !halt) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (redir) begin
                    pc_en     = 1'b1;
                    pc_jump   = jmp_taken;
                    pc_branch = br_taken & ~jmp_taken;
                end
                // pc_cur is stale during a redirect cycle, so no request goes out then.
                if (halt) begin
                    state_nxt = IDLE;
                end else if (!redir && slot_free) begin
                    imem_req  = 1'b1;
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_en = 1'b1;
                    if (redir) begin
                        pc_jump   = jmp_taken;
                        pc_branch = br_taken & ~jmp_taken;
                    end else if (pend_valid) begin
                        pc_jump   = pend_jmp;
                        pc_branch = ~pend_jmp;
                    end
                    state_nxt = (halt || halt_pend) ? IDLE : FETCH;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_tc) begin
                    state_nxt = ERR;
                end
`endif
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= 16'h0000;
            br_q        <= 16'h0000;
            jmp_q       <= 16'h0000;
            pend_valid  <= 1'b0;
            pend_jmp    <= 1'b0;
            halt_pend   <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                addr_q <= pc_cur;
            end
            if (br_taken && active) begin
                br_q <= br_addr;
            end
            if (jmp_taken && active) begin
                jmp_q <= jmp_addr;
            end
            // Redirect and halt seen mid-access are held until the ack; the latest redirect wins.
            if (state == WAIT && !imem_ack) begin
                halt_pend <= halt_pend | halt;
                if (redir) begin
                    pend_valid <= 1'b1;
                    pend_jmp   <= jmp_taken;
                end
            end else begin
                halt_pend  <= 1'b0;
                pend_valid <= 1'b0;
                pend_jmp   <= 1'b0;
            end
            if (flush) begin
                instr_valid <= 1'b0;
            end else if (deliver) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= addr_q;
            end else if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; models the PC register around the DUT and checks hand-computed values.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, halt;
    logic [15:0] pc_cur = 16'h0000;
    logic        pc_en, pc_branch, pc_jump;
    logic [15:0] pc_seq, br_target, jmp_target;
    logic        br_taken, jmp_taken;
    logic [15:0] br_addr, jmp_addr;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic [15:0] instr, instr_pc;
    logic        instr_valid, instr_ready;
    logic        busy, fetch_err;
    logic        pc_load;
    logic [15:0] pc_load_val;
    int          checks = 0;
    int          failures = 0;

    fetch_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .halt       (halt),
        .pc_cur     (pc_cur),
        .pc_en      (pc_en),
        .pc_seq     (pc_seq),
        .pc_branch  (pc_branch),
        .pc_jump    (pc_jump),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .jmp_taken  (jmp_taken),
        .jmp_addr   (jmp_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clock = ~clock;

    // PC register seen by the DUT; pc_load lets the bench preset it.
    always @(posedge clock) begin
        if (pc_load) pc_cur <= pc_load_val;
        else if (pc_en) pc_cur <= pc_jump ? jmp_target : (pc_branch ? br_target : pc_seq);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; halt = 1'b0;
        br_taken = 1'b0; br_addr = 16'h0; jmp_taken = 1'b0; jmp_addr = 16'h0;
        imem_ack = 1'b0; imem_rdata = 16'h0; instr_ready = 1'b0;
        pc_load = 1'b0; pc_load_val = 16'h0;
        #1;
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_pc_seq", 32'(pc_seq), 32'h0001);
        step(); step();
        reset_n = 1'b1;

        // start together with halt: halt wins
        start = 1'b1; halt = 1'b1;
        step();
        check("start_halt_busy", 32'(busy), 32'd0);
        halt = 1'b0;
        #1;
        check("idle_no_req", 32'(imem_req), 32'd0);

        // test 1: first fetch from 0x0000, ack one cycle after req
        step();
        start = 1'b0;
        #1;
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'h0000);
        check("t1_busy", 32'(busy), 32'd1);
        step();
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        #1;
        check("t1_pc_en", 32'(pc_en), 32'd1);
        check("t1_sel", 32'({pc_jump, pc_branch}), 32'd0);
        check("t1_pc_seq", 32'(pc_seq), 32'h0001);
        check("t1_valid_early", 32'(instr_valid), 32'd0);
        step();
        imem_ack = 1'b0;
        #1;
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", 32'(instr), 32'h1234);
        check("t1_instr_pc", 32'(instr_pc), 32'h0000);
        check("t1_pc_en_once", 32'(pc_en), 32'd0);

        // test 4: slot held full for 5 cycles, then ready issues in the same cycle
        for (int i = 0; i < 5; i++) begin
            check("t4_no_req", 32'(imem_req), 32'd0);
            check("t4_instr", 32'(instr), 32'h1234);
            step();
        end
        instr_ready = 1'b1;
        #1;
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", 32'(imem_addr), 32'h0001);
        step();
        instr_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        check("t4_consumed", 32'(instr_valid), 32'd0);
        check("t4_pc_en", 32'(pc_en), 32'd1);
        step();
        imem_ack = 1'b0;
        #1;
        check("t4_instr", 32'(instr), 32'hBEEF);
        check("t4_instr_pc", 32'(instr_pc), 32'h0001);

        // test 2: wrap at 0xFFFF
        pc_load = 1'b1; pc_load_val = 16'hFFFF;
        step();
        pc_load = 1'b0;
        #1;
        check("t2_pc_seq", 32'(pc_seq), 32'h0000);
        instr_ready = 1'b1;
        #1;
        check("t2_addr", 32'(imem_addr), 32'hFFFF);
        step();
        instr_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h5A5A;
        #1;
        check("t2_pc_en", 32'(pc_en), 32'd1);
        step();
        imem_ack = 1'b0;
        #1;
        check("t2_instr_pc", 32'(instr_pc), 32'hFFFF);
        check("t2_instr", 32'(instr), 32'h5A5A);
        check("t2_pc_wrapped", 32'(pc_cur), 32'h0000);

        // test 3: jump and branch together during WAIT; jump wins, data dropped
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        jmp_taken = 1'b1; jmp_addr = 16'h0200; br_taken = 1'b1; br_addr = 16'h0100;
        #1;
        check("t3_no_pc_en_wait", 32'(pc_en), 32'd0);
        step();
        jmp_taken = 1'b0; br_taken = 1'b0; jmp_addr = 16'h0; br_addr = 16'h0;
        #1;
        check("t3_jmp_latched", 32'(jmp_target), 32'h0200);
        check("t3_br_latched", 32'(br_target), 32'h0100);
        check("t3_req_held", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        #1;
        check("t3_pc_en", 32'(pc_en), 32'd1);
        check("t3_sel", 32'({pc_jump, pc_branch}), 32'b10);
        step();
        imem_ack = 1'b0;
        #1;
        check("t3_dropped", 32'(instr_valid), 32'd0);
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_addr", 32'(imem_addr), 32'h0200);
        step();
        imem_ack = 1'b1; imem_rdata = 16'h0777;
        #1;
        check("t3_seq_sel", 32'({pc_en, pc_jump, pc_branch}), 32'b100);
        step();
        imem_ack = 1'b0;
        #1;
        check("t3_instr", 32'(instr), 32'h0777);
        check("t3_instr_pc", 32'(instr_pc), 32'h0200);

        // immediate branch in FETCH flushes the full slot
        br_taken = 1'b1; br_addr = 16'h0300;
        #1;
        check("br_pc_en", 32'(pc_en), 32'd1);
        check("br_sel", 32'({pc_jump, pc_branch}), 32'b01);
        check("br_target", 32'(br_target), 32'h0300);
        check("br_no_req", 32'(imem_req), 32'd0);
        step();
        br_taken = 1'b0; br_addr = 16'h0;
        #1;
        check("br_flushed", 32'(instr_valid), 32'd0);
        check("br_addr_next", 32'(imem_addr), 32'h0300);

        // test 5: halt in WAIT, ack three cycles later
        step();
        halt = 1'b1;
        #1;
        check("t5_req", 32'(imem_req), 32'd1);
        step(); step(); step();
        imem_ack = 1'b1; imem_rdata = 16'h4321;
        #1;
        check("t5_pc_en", 32'(pc_en), 32'd1);
        step();
        imem_ack = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(instr_valid), 32'd1);
        check("t5_instr", 32'(instr), 32'h4321);
        check("t5_instr_pc", 32'(instr_pc), 32'h0300);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_req", 32'(imem_req), 32'd0);
        end
        halt = 1'b0;

        // test 6: ack withheld
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("t6_slot_kept", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        #1;
        check("t6_addr", 32'(imem_addr), 32'h0301);
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("t6_waiting", 32'({imem_req, fetch_err}), 32'b10);
        end
        step();
`ifdef FETCH_TIMEOUT_EN
        check("t6_err", 32'({imem_req, fetch_err, pc_en}), 32'b010);
`else
        check("t6_no_timeout", 32'({imem_req, fetch_err}), 32'b10);
`endif

        // reset mid-access, then a late ack in IDLE
        reset_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(imem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_err", 32'(fetch_err), 32'd0);
        step();
        reset_n = 1'b1;
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        #1;
        check("late_ack_pc_en", 32'(pc_en), 32'd0);
        step();
        imem_ack = 1'b0;
        #1;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
